// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath: default byte width and destination codes.
package router_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_ECW = 8;

  typedef enum logic [1:0] {
    ADDR0    = 2'b00,
    ADDR1    = 2'b01,
    ADDR2    = 2'b10,
    ADDR_INV = 2'b11
  } dest_e;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity of the packet and the captured packet parity byte, with their comparison.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          acc_en,
  input  logic [DW-1:0] acc_data,
  input  logic          cap_en,
  input  logic [DW-1:0] cap_data,
  output logic          mismatch
);

  logic [DW-1:0] int_par_q, int_par_d;
  logic [DW-1:0] pkt_par_q, pkt_par_d;

  always_comb begin
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    if (clr)         int_par_d = '0;
    else if (acc_en) int_par_d = int_par_q ^ acc_data;
    if (cap_en)      pkt_par_d = cap_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_par_q <= '0;
      pkt_par_q <= '0;
    end else begin
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
    end
  end

  assign mismatch = (int_par_q != pkt_par_q);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, payload forwarding, full-FIFO byte parking, parity check.
// Optional saturating parity-error counter enabled by defining ERR_CNT_EN.
module router_reg
  import router_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int ECW = DEF_ECW
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           pktvalid,
  input  logic [DW-1:0]  datain,
  input  logic           fifofull,
  input  logic           detectadd,
  input  logic           lfdstate,
  input  logic           ldstate,
  input  logic           fullstate,
  input  logic           lafstate,
  input  logic           rstintreg,
  output logic [DW-1:0]  dout,
  output logic           paritydone,
  output logic           lowpktvalid,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  logic [DW-1:0] header_q, header_d;
  logic [DW-1:0] ffhold_q, ffhold_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          paritydone_q, paritydone_d;
  logic          lowpktvalid_q, lowpktvalid_d;
  logic          err_q, err_d;

  logic          acc_en, cap_ld, cap_laf, cap_en, mismatch, err_set;
  logic [DW-1:0] acc_data, cap_data;

  // The parity byte (pktvalid low) is never folded; it is captured instead.
  assign acc_en   = lfdstate | (ldstate & pktvalid & ~fifofull) | (lafstate & ~lowpktvalid_q);
  assign acc_data = lfdstate ? header_q : (ldstate ? datain : ffhold_q);
  assign cap_ld   = ldstate & ~pktvalid & ~fifofull;
  assign cap_laf  = lafstate & lowpktvalid_q & ~paritydone_q;
  assign cap_en   = cap_ld | cap_laf;
  assign cap_data = cap_ld ? datain : ffhold_q;
  assign err_set  = rstintreg & paritydone_q & mismatch;

  router_parity_acc #(.DW(DW)) u_parity (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (detectadd),
    .acc_en   (acc_en),
    .acc_data (acc_data),
    .cap_en   (cap_en),
    .cap_data (cap_data),
    .mismatch (mismatch)
  );

  always_comb begin
    header_d      = header_q;
    ffhold_d      = ffhold_q;
    dout_d        = dout_q;
    paritydone_d  = paritydone_q;
    lowpktvalid_d = lowpktvalid_q;
    err_d         = err_q;

    if (detectadd && pktvalid && (datain[1:0] != ADDR_INV)) header_d = datain;

    if (lfdstate)                   dout_d = header_q;
    else if (ldstate && !fifofull)  dout_d = datain;
    else if (lafstate)              dout_d = ffhold_q;

    // The parked byte is held untouched through the full state.
    if (ldstate && fifofull) ffhold_d = datain;
    else if (fullstate)      ffhold_d = ffhold_q;

    if (detectadd)   paritydone_d = 1'b0;
    else if (cap_en) paritydone_d = 1'b1;

    if (rstintreg)                lowpktvalid_d = 1'b0;
    else if (ldstate && !pktvalid) lowpktvalid_d = 1'b1;

    if (rstintreg && paritydone_q)   err_d = mismatch;
    else if (detectadd && pktvalid)  err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header_q      <= '0;
      ffhold_q      <= '0;
      dout_q        <= '0;
      paritydone_q  <= 1'b0;
      lowpktvalid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      header_q      <= header_d;
      ffhold_q      <= ffhold_d;
      dout_q        <= dout_d;
      paritydone_q  <= paritydone_d;
      lowpktvalid_q <= lowpktvalid_d;
      err_q         <= err_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [ECW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_set && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_set;
  assign unused_err_set = err_set;
  assign err_cnt        = '0;
`endif

  assign dout        = dout_q;
  assign paritydone  = paritydone_q;
  assign lowpktvalid = lowpktvalid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed-vector bench for router_reg; compile with ERR_CNT_EN defined to exercise the error counter.
module tb_router_reg;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_FULL = 6'b000100;
  localparam logic [5:0] S_LAF  = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pktvalid;
  logic [7:0] datain;
  logic       fifofull;
  logic       detectadd, lfdstate, ldstate, fullstate, lafstate, rstintreg;
  logic [7:0] dout;
  logic       paritydone, lowpktvalid, err;
  logic [7:0] err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_cnt  = '0;

  always #5 clk = ~clk;

  router_reg #(.DW(8), .ECW(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pktvalid    (pktvalid),
    .datain      (datain),
    .fifofull    (fifofull),
    .detectadd   (detectadd),
    .lfdstate    (lfdstate),
    .ldstate     (ldstate),
    .fullstate   (fullstate),
    .lafstate    (lafstate),
    .rstintreg   (rstintreg),
    .dout        (dout),
    .paritydone  (paritydone),
    .lowpktvalid (lowpktvalid),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {detectadd, lfdstate, ldstate, fullstate, lafstate, rstintreg} = st;
    pktvalid = pv;
    datain   = d;
    fifofull = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic count_err();
`ifdef ERR_CNT_EN
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
  endtask

  // Header 05, parity byte FF: int_par=05 vs pkt_par=FF -> mismatch.
  task automatic bad_pkt();
    tick(S_DA,  1'b1, 8'h05, 1'b0);
    tick(S_LFD, 1'b1, 8'h00, 1'b0);
    tick(S_LD,  1'b0, 8'hFF, 1'b0);
    tick(S_RST, 1'b0, 8'h00, 1'b0);
    count_err();
  endtask

  initial begin
    resetn = 1'b0;
    tick(S_NONE, 1'b0, 8'h00, 1'b0);
    tick(S_NONE, 1'b0, 8'h00, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_pdone", paritydone, 1'b0);
    check("rst_lowpv", lowpktvalid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cnt", err_cnt, 8'h00);
    resetn = 1'b1;

    // Good packet: 05 | 11 22 33 | parity 05
    tick(S_DA,  1'b1, 8'h05, 1'b0);
    tick(S_LFD, 1'b1, 8'h00, 1'b0); check("g_hdr", dout, 8'h05);
    tick(S_LD,  1'b1, 8'h11, 1'b0); check("g_d1", dout, 8'h11);
    tick(S_LD,  1'b1, 8'h22, 1'b0); check("g_d2", dout, 8'h22);
    tick(S_LD,  1'b1, 8'h33, 1'b0); check("g_d3", dout, 8'h33);
    check("g_pdone0", paritydone, 1'b0);
    tick(S_LD,  1'b0, 8'h05, 1'b0); check("g_par", dout, 8'h05);
    check("g_pdone1", paritydone, 1'b1);
    check("g_lowpv1", lowpktvalid, 1'b1);
    tick(S_RST, 1'b0, 8'h00, 1'b0);
    check("g_err", err, 1'b0);
    check("g_lowpv0", lowpktvalid, 1'b0);
    check("g_cnt", err_cnt, exp_cnt);

    // Same packet, parity FF
    tick(S_DA,  1'b1, 8'h05, 1'b0);
    tick(S_LFD, 1'b1, 8'h00, 1'b0);
    tick(S_LD,  1'b1, 8'h11, 1'b0);
    tick(S_LD,  1'b1, 8'h22, 1'b0);
    tick(S_LD,  1'b1, 8'h33, 1'b0);
    tick(S_LD,  1'b0, 8'hFF, 1'b0); check("b_pdone", paritydone, 1'b1);
    check("b_err_pre", err, 1'b0);
    tick(S_RST, 1'b0, 8'h00, 1'b0);
    count_err();
    check("b_err", err, 1'b1);
    check("b_cnt", err_cnt, exp_cnt);

    // fifofull on payload byte 22
    tick(S_DA,   1'b1, 8'h05, 1'b0); check("f_errclr", err, 1'b0);
    check("f_pdclr", paritydone, 1'b0);
    tick(S_LFD,  1'b1, 8'h00, 1'b0); check("f_hdr", dout, 8'h05);
    tick(S_LD,   1'b1, 8'h11, 1'b0); check("f_d1", dout, 8'h11);
    tick(S_LD,   1'b1, 8'h22, 1'b1); check("f_park", dout, 8'h11);
    tick(S_FULL, 1'b1, 8'h00, 1'b1); check("f_full", dout, 8'h11);
    tick(S_LAF,  1'b1, 8'h00, 1'b0); check("f_laf", dout, 8'h22);
    check("f_laf_pd", paritydone, 1'b0);
    tick(S_LD,   1'b1, 8'h33, 1'b0); check("f_d3", dout, 8'h33);
    tick(S_LD,   1'b0, 8'h05, 1'b0); check("f_par", dout, 8'h05);
    tick(S_RST,  1'b0, 8'h00, 1'b0); check("f_err", err, 1'b0);

    // Leave stale pkt_par=FF, then fifofull rises on the parity byte
    bad_pkt();
    check("s_err", err, 1'b1);
    tick(S_DA,   1'b1, 8'h05, 1'b0);
    tick(S_LFD,  1'b1, 8'h00, 1'b0);
    tick(S_LD,   1'b1, 8'h11, 1'b0);
    tick(S_LD,   1'b1, 8'h22, 1'b0);
    tick(S_LD,   1'b1, 8'h33, 1'b0);
    tick(S_LD,   1'b0, 8'h05, 1'b1); check("p_dout", dout, 8'h33);
    check("p_lowpv", lowpktvalid, 1'b1);
    check("p_pd0", paritydone, 1'b0);
    tick(S_FULL, 1'b0, 8'h00, 1'b1); check("p_pd_full", paritydone, 1'b0);
    tick(S_LAF,  1'b0, 8'h00, 1'b0); check("p_laf", dout, 8'h05);
    check("p_pd1", paritydone, 1'b1);
    tick(S_RST,  1'b0, 8'h00, 1'b0); check("p_err", err, 1'b0);
    check("p_cnt", err_cnt, exp_cnt);

    // Invalid destination 2'b11 must not replace header 05
    tick(S_DA,  1'b1, 8'h07, 1'b0);
    tick(S_LFD, 1'b1, 8'h00, 1'b0); check("inv_hdr", dout, 8'h05);

    // Asynchronous reset mid-payload after an error
    bad_pkt();
    check("r_err_pre", err, 1'b1);
    tick(S_LFD, 1'b1, 8'h00, 1'b0);
    tick(S_LD,  1'b1, 8'h11, 1'b0); check("r_d1", dout, 8'h11);
    #2 resetn = 1'b0;
    #1;
    exp_cnt = '0;
    check("r_dout", dout, 8'h00);
    check("r_err", err, 1'b0);
    check("r_pdone", paritydone, 1'b0);
    check("r_cnt", err_cnt, 8'h00);
    #1 resetn = 1'b1;
    // Header and int_par both cleared: header 00 folds to 0, matches parity 00
    tick(S_LFD, 1'b1, 8'h00, 1'b0); check("r_hdr", dout, 8'h00);
    tick(S_LD,  1'b0, 8'h00, 1'b0); check("r_pd", paritydone, 1'b1);
    tick(S_RST, 1'b0, 8'h00, 1'b0); check("r_par", err, 1'b0);

    // Counter saturation: 2^8+3 bad packets
    for (int i = 0; i < 259; i++) begin
      bad_pkt();
      if (i == 0)   check("sat_1", err_cnt, exp_cnt);
      if (i == 254) check("sat_255", err_cnt, exp_cnt);
    end
    check("sat_end", err_cnt, exp_cnt);
`ifdef ERR_CNT_EN
    check("sat_ones", err_cnt, 8'hFF);
`else
    check("cnt_zero", err_cnt, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
